// File: rtl/mem_debug_viewer_pkg.sv
// Shared types, segment glyph table and nibble decoder for the memory debug viewer.
// Imported by the step debouncer and the mem_debug_viewer top level.
package mem_debug_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } deb_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element, lowercase b and d.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E,   // F
      7'h06,   // E
      7'h21,   // d
      7'h46,   // C
      7'h03,   // b
      7'h08,   // A
      7'h10,   // 9
      7'h00,   // 8
      7'h78,   // 7
      7'h02,   // 6
      7'h12,   // 5
      7'h19,   // 4
      7'h30,   // 3
      7'h24,   // 2
      7'h79,   // 1
      7'h40    // 0
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      return SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/mem_debug_viewer_step_debouncer.sv
// Push-button synchroniser and debounce FSM producing one writeEnable pulse per
// accepted press; a button held through reset must be released before it can fire.
module step_debouncer
   import mem_debug_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic Clk,
   input  logic Rst,
   input  logic btnStep_n,
   output logic writeEnable
);

   localparam int CNT_NEED = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CNT_BITS = (CNT_NEED > 16) ? CNT_NEED : 16;
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
   localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

   logic                sync1_reg;
   logic                sync2_reg;
   logic [1:0]          valid_reg;
   logic                armed_reg;
   deb_state_t          state_reg;
   deb_state_t          state_next;
   logic [CNT_BITS-1:0] cnt_reg;
   logic [CNT_BITS-1:0] cnt_next;
   logic                pulse_next;
   logic                pressed;

   assign pressed = ~sync2_reg;

   // valid_reg marks when sync2 holds a real pin sample rather than its reset value;
   // only a genuine release observed after reset arms the FSM.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         valid_reg <= 2'b00;
         armed_reg <= 1'b0;
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= btnStep_n;
         sync2_reg <= sync1_reg;
         valid_reg <= {valid_reg[0], 1'b1};
         armed_reg <= armed_reg | (valid_reg[1] & ~pressed);
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pulse_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pressed && armed_reg) begin
               state_next = PRESS_WAIT;
               cnt_next   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!pressed) begin
               state_next = IDLE;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = HELD;
               pulse_next = 1'b1;
            end else if (cnt_reg != CNT_MAX) begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         HELD: begin
            if (!pressed) begin
               state_next = RELEASE_WAIT;
               cnt_next   = '0;
            end
         end
         RELEASE_WAIT: begin
            // A re-press here is release bounce: return to HELD without a pulse.
            if (pressed) begin
               state_next = HELD;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = IDLE;
            end else if (cnt_reg != CNT_MAX) begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign writeEnable = pulse_next;

endmodule

// File: rtl/mem_debug_viewer.sv
// Front-panel debug initiator: clamped peek address, debounced step pulse and hex display.
// Define MEM_DEBUG_STEP_COUNT_EN to add the stepCount pulse counter output.
module mem_debug_viewer
   import mem_debug_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int ADDR_BITS       = 9,
   parameter int PEEK_LIMIT      = 128
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [ADDR_BITS-1:0] sw,
   input  logic                 halfSel,
   input  logic                 btnStep_n,
   input  logic [31:0]          peekData,
   output logic [31:0]          peekAddr,
   output logic                 writeEnable,
   output logic                 overRange,
   output logic [6:0]           hex3,
   output logic [6:0]           hex2,
   output logic [6:0]           hex1,
   output logic [6:0]           hex0
`ifdef MEM_DEBUG_STEP_COUNT_EN
   ,
   output logic [15:0]          stepCount
`endif
);

   localparam logic [31:0] LIMIT_W = 32'(PEEK_LIMIT);

   logic [31:0]      sw_wide;
   logic             in_range;
   logic [31:0]      addr_next;
   logic [31:0]      peek_addr_reg;
   logic             over_range_reg;
   logic [31:0]      data_reg;
   logic             half_sel_reg;
   logic             blank_reg;
   logic [15:0]      half_word;
   logic [3:0][6:0]  hex_seg;
   logic             step_pulse;

   assign sw_wide   = 32'(sw);
   assign in_range  = (sw_wide < LIMIT_W);
   assign addr_next = in_range ? sw_wide : (LIMIT_W - 32'd1);

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         peek_addr_reg  <= '0;
         over_range_reg <= 1'b0;
      end else begin
         peek_addr_reg  <= addr_next;
         over_range_reg <= ~in_range;
      end
   end

   assign peekAddr  = peek_addr_reg;
   assign overRange = over_range_reg;

   // halfSel is captured with the data so a toggle shows up with the same one-cycle latency.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         data_reg     <= '0;
         half_sel_reg <= 1'b0;
         blank_reg    <= 1'b1;
      end else begin
         data_reg     <= peekData;
         half_sel_reg <= halfSel;
         blank_reg    <= 1'b0;
      end
   end

   assign half_word = half_sel_reg ? data_reg[31:16] : data_reg[15:0];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         assign hex_seg[gi] = blank_reg ? SEG_BLANK : hex_to_seg(half_word[gi*4 +: 4]);
      end
   endgenerate

   assign hex0 = hex_seg[0];
   assign hex1 = hex_seg[1];
   assign hex2 = hex_seg[2];
   assign hex3 = hex_seg[3];

   step_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_step (
      .Clk         (Clk),
      .Rst         (Rst),
      .btnStep_n   (btnStep_n),
      .writeEnable (step_pulse)
   );

   assign writeEnable = step_pulse;

`ifdef MEM_DEBUG_STEP_COUNT_EN
   logic [15:0] step_count_reg;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         step_count_reg <= '0;
      end else if (step_pulse) begin
         step_count_reg <= step_count_reg + 16'd1;
      end
   end

   assign stepCount = step_count_reg;
`endif

endmodule

// File: doc/mem_debug_viewer.md
Name: mem_debug_viewer

Overview:
- Front-panel debug initiator for the data memory's debug side.
- Drives the memory's peek address from the board switches.
- Converts the raw step push-button into a debounced single-cycle writeEnable pulse that releases one pending store.
- Registers the returned peekData and decodes a selected halfword onto four active-low 7-segment displays.

Parameters:
- DEBOUNCE_CYCLES, 50000: cycles the synchronised button must be stable before a press or release is accepted (1 ms at 50 MHz).
- ADDR_BITS, 9: number of address switches.
- PEEK_LIMIT, 128: first peek address not backed by the debug port; higher addresses are clamped.

Ports:
- Clk  in  1  system clock, all logic on posedge.
- Rst  in  1  synchronous reset, active-low.
- sw  in  ADDR_BITS  raw address switches, treated as quasi-static.
- halfSel  in  1  0 = show peekData[15:0], 1 = show peekData[31:16].
- btnStep_n  in  1  raw asynchronous push-button, active-low.
- peekData  in  32  debug read data from data memory, combinational from peekAddr.
- peekAddr  out  32  debug address to data memory.
- writeEnable  out  1  one-cycle pulse per accepted button press.
- overRange  out  1  high while the switch value is at or above PEEK_LIMIT.
- hex3, hex2, hex1, hex0  out  7 each  segment drives {g,f,e,d,c,b,a}, active-low; hex3 is the most significant nibble.

Behaviour:
- Reset (Rst==0 at posedge):
  - peekAddr=0, writeEnable=0, overRange=0.
  - All hex outputs = 7'h7F (blank).
  - Debounce FSM = IDLE, counter=0.
  - Both synchroniser flops = 1 (released).
- Reset mid-press: FSM returns to IDLE. A button still held after reset must be released before any further pulse is produced.
- Synchroniser: 2-flop on btnStep_n; pressed = ~sync2.
- Address path (registered, 1-cycle latency): peekAddr = zero-extend(sw) if sw < PEEK_LIMIT, else PEEK_LIMIT-1. overRange is registered alongside it.
- Display path:
  - Data register captures peekData every cycle.
  - Hex digits decode from the data register on the same edge, giving 1 cycle of latency from peekData and 2 cycles from sw.
  - Encoding is 0-F, standard hex glyphs, lowercase b and d.
  - halfSel is applied in the decode and takes effect with that 1-cycle latency.
- Debounce FSM; counter is 16 bit minimum and saturates:
  - IDLE: pressed -> PRESS_WAIT, counter=0.
  - PRESS_WAIT: released -> IDLE. Else counter++. When counter==DEBOUNCE_CYCLES-1 -> HELD, and writeEnable=1 for exactly this one cycle.
  - HELD: released -> RELEASE_WAIT, counter=0. No further pulses while held, regardless of hold length.
  - RELEASE_WAIT: pressed -> HELD, with no pulse (bounce on release). When counter==DEBOUNCE_CYCLES-1 -> IDLE.
- Latency: stable press at pin -> writeEnable pulse = 2 + DEBOUNCE_CYCLES cycles.
- writeEnable is never high two consecutive cycles. Minimum spacing between pulses is 2*DEBOUNCE_CYCLES cycles.
- Address change and pulse in the same cycle: both proceed independently; the pulse does not sample sw.
- DEBOUNCE_CYCLES==1 is legal: the pulse comes the first cycle after entering PRESS_WAIT.

Optional Feature:
- Macro MEM_DEBUG_STEP_COUNT_EN.
- Defined: adds output stepCount[15:0], counting writeEnable pulses. It resets to 0, wraps 16'hFFFF -> 0, and increments in the same cycle the pulse is high (the new value is visible the following cycle).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_debug_pkg holds:
  - Debounce state enum: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - SEG_BLANK = 7'h7F.
  - 16-entry nibble-to-segment constant table.
  - hex_to_seg function.
- One sub-module, step_debouncer, contains the synchroniser, FSM, counter and pulse output, parameterised by DEBOUNCE_CYCLES.
- Top level holds the address clamp, data register, hex decode, and the optional counter.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold Rst=0 for 2 cycles with sw=9'h005 -> peekAddr=0, writeEnable=0, hex*=7'h7F. One cycle after Rst=1 -> peekAddr=32'h5.
- Clamp: sw=9'd200 -> peekAddr=32'd127, overRange=1. Then sw=9'd127 -> peekAddr=127, overRange=0.
- Display: peekData=32'hDEADBEEF, halfSel=1 -> hex3..0 show d,E,A,d. Toggle halfSel=0 -> next cycle shows b,E,E,F.
- Clean press: btnStep_n low at cycle 0 and held 20 cycles -> exactly one writeEnable pulse at cycle 6 and none after. Release, wait 10 cycles, press again -> a second single pulse.
- Bounce: press 2 cycles / release 1 cycle / press 2 cycles, then release -> no pulse. Release bounces while in HELD -> no extra pulse.
- Reset mid-press: assert Rst in PRESS_WAIT at counter=2 while the button stays low -> no pulse until released, then pressed again. With MEM_DEBUG_STEP_COUNT_EN, 3 accepted presses -> stepCount=3.
